ttl_and3_tester: RTL and testbench

Synthesizable pin-level exerciser for a triple 3-input AND device (7411 pinout, 14-pin DIP). It drives the nine gate-input pins and the supply pins. For each gate it walks all 8 input combinations, samples the three gate outputs, compares them against the AND function, and reports test and error counts with a start/done handshake. It sits on the tester side of the chip's pin interface, so it can qualify either a socketed part or a `sn7411` model on the bench.

---
 rtl/ttl_and3_tester.sv | 191 +++++++++++++++++++
 tb/tb_ttl_and3_tester.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ttl_and3_tester.sv
// ttl_and3_tester: pin-level exerciser for a triple 3-input AND device
// (7411 pinout). Walks all 8 input vectors across gates A, B and C,
// samples the synchronized gate outputs and accumulates results.
module ttl_and3_tester #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             p1,
  output logic             p2,
  output logic             p13,
  output logic             p3,
  output logic             p4,
  output logic             p5,
  output logic             p9,
  output logic             p10,
  output logic             p11,
  output logic             p14,
  output logic             p7,
  input  logic             p12,
  input  logic             p6,
  input  logic             p8,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] error_count,
  output logic [2:0]       err_gate,
  output logic [4:0]       first_fail,
  output logic             first_fail_vld
);

  // Two synchronizer stages need at least two settle cycles to see new data.
  localparam int SETTLE_E = (SETTLE < 2) ? 2 : SETTLE;
  localparam int WAIT_W   = $clog2(SETTLE_E);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        r_vec;
  logic [1:0]        r_g;
  logic [WAIT_W-1:0] r_wait;
  logic [8:0]        r_pins;   // {p11,p10,p9, p5,p4,p3, p13,p2,p1}
  logic [2:0]        r_sync1;  // [0]=A(p12) [1]=B(p6) [2]=C(p8)
  logic [2:0]        r_sync2;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_test_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [2:0]        r_err_gate;
  logic [4:0]        r_first_fail;
  logic              r_first_vld;

  logic              w_obs;
  logic              w_exp;
  logic              w_mismatch;
  logic [2:0]        w_gate_bit;
  logic              w_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Select the synchronized output and one-hot flag of the gate under test.
  always_comb begin
    w_obs      = 1'b0;
    w_gate_bit = 3'b000;
    case (r_g)
      2'd0:    begin w_obs = r_sync2[0]; w_gate_bit = 3'b001; end
      2'd1:    begin w_obs = r_sync2[1]; w_gate_bit = 3'b010; end
      2'd2:    begin w_obs = r_sync2[2]; w_gate_bit = 3'b100; end
      default: begin w_obs = 1'b0;       w_gate_bit = 3'b000; end
    endcase
  end

  assign w_exp      = &r_vec;
  assign w_mismatch = (w_obs != w_exp);
  assign w_last     = (r_vec == 3'd7) && (r_g == 2'd2);

  // Two-flop synchronizer on the three device outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {p8, p6, p12};
      r_sync2 <= r_sync1;
    end
  end

  // Sequencer: drive a vector, wait for settle, check, accumulate results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= 3'd0;
      r_g          <= 2'd0;
      r_wait       <= '0;
      r_pins       <= 9'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_test_cnt   <= '0;
      r_err_cnt    <= '0;
      r_err_gate   <= 3'b000;
      r_first_fail <= 5'd0;
      r_first_vld  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_test_cnt   <= '0;
            r_err_cnt    <= '0;
            r_err_gate   <= 3'b000;
            r_first_fail <= 5'd0;
            r_first_vld  <= 1'b0;
            r_vec        <= 3'd0;
            r_g          <= 2'd0;
            r_busy       <= 1'b1;
            r_state      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          case (r_g)
            2'd0:    r_pins[2:0] <= {r_vec[0], r_vec[1], r_vec[2]};
            2'd1:    r_pins[5:3] <= {r_vec[0], r_vec[1], r_vec[2]};
            default: r_pins[8:6] <= {r_vec[0], r_vec[1], r_vec[2]};
          endcase
          r_wait  <= WAIT_W'(SETTLE_E - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_CHECK: begin
          r_test_cnt <= sat_inc(r_test_cnt);
          if (w_mismatch) begin
            r_err_cnt  <= sat_inc(r_err_cnt);
            r_err_gate <= r_err_gate | w_gate_bit;
            if (!r_first_vld) begin
              r_first_fail <= {r_g, r_vec};
              r_first_vld  <= 1'b1;
            end
          end
          if (r_g < 2'd2) begin
            r_g <= r_g + 2'd1;
          end else begin
            r_g   <= 2'd0;
            r_vec <= r_vec + 3'd1;
          end
          r_state <= w_last ? S_DONE : S_DRIVE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p1  = r_pins[0];
  assign p2  = r_pins[1];
  assign p13 = r_pins[2];
  assign p3  = r_pins[3];
  assign p4  = r_pins[4];
  assign p5  = r_pins[5];
  assign p9  = r_pins[6];
  assign p10 = r_pins[7];
  assign p11 = r_pins[8];
  assign p14 = 1'b1;
  assign p7  = 1'b0;

  assign busy           = r_busy;
  assign done           = r_done;
  assign test_count     = r_test_cnt;
  assign error_count    = r_err_cnt;
  assign err_gate       = r_err_gate;
  assign first_fail     = r_first_fail;
  assign first_fail_vld = r_first_vld;

endmodule

// File: tb/tb_ttl_and3_tester.sv
// Bench for ttl_and3_tester: two instances (SETTLE=2 and SETTLE=4) each
// wired to a behavioural 7411 with an optional stuck-at output fault.
module tb_ttl_and3_tester;

  logic clk;
  logic rst_n;
  logic st [2];

  wire       busy_w [2];
  wire       done_w [2];
  wire [7:0] tc_w   [2];
  wire [7:0] ec_w   [2];
  wire [2:0] eg_w   [2];
  wire [4:0] ff_w   [2];
  wire       ffv_w  [2];
  wire [8:0] drv    [2];  // {p11,p10,p9, p5,p4,p3, p13,p2,p1}
  wire       p14_w  [2];
  wire       p7_w   [2];
  wire       dA     [2];
  wire       dB     [2];
  wire       dC     [2];

  // Fault injection: 0 none, 1 gate A (p12), 2 gate B (p6), 3 gate C (p8)
  int   fault_pin;
  logic fault_val;

  int n_vec;
  int n_miss;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    assign dA[k] = (fault_pin == 1) ? fault_val : (&drv[k][2:0]);
    assign dB[k] = (fault_pin == 2) ? fault_val : (&drv[k][5:3]);
    assign dC[k] = (fault_pin == 3) ? fault_val : (&drv[k][8:6]);

    ttl_and3_tester #(.SETTLE((k == 0) ? 2 : 4), .CNT_W(8)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (st[k]),
      .p1            (drv[k][0]),
      .p2            (drv[k][1]),
      .p13           (drv[k][2]),
      .p3            (drv[k][3]),
      .p4            (drv[k][4]),
      .p5            (drv[k][5]),
      .p9            (drv[k][6]),
      .p10           (drv[k][7]),
      .p11           (drv[k][8]),
      .p14           (p14_w[k]),
      .p7            (p7_w[k]),
      .p12           (dA[k]),
      .p6            (dB[k]),
      .p8            (dC[k]),
      .busy          (busy_w[k]),
      .done          (done_w[k]),
      .test_count    (tc_w[k]),
      .error_count   (ec_w[k]),
      .err_gate      (eg_w[k]),
      .first_fail    (ff_w[k]),
      .first_fail_vld(ffv_w[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_state(input int w, input string tag);
    chk({tag, "_busy"}, {31'd0, busy_w[w]}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_w[w]}, 32'd0);
    chk({tag, "_tc"},   {24'd0, tc_w[w]},   32'd0);
    chk({tag, "_ec"},   {24'd0, ec_w[w]},   32'd0);
    chk({tag, "_eg"},   {29'd0, eg_w[w]},   32'd0);
    chk({tag, "_ff"},   {27'd0, ff_w[w]},   32'd0);
    chk({tag, "_ffv"},  {31'd0, ffv_w[w]},  32'd0);
    chk({tag, "_pins"}, {23'd0, drv[w]},    32'd0);
    chk({tag, "_vcc"},  {31'd0, p14_w[w]},  32'd1);
    chk({tag, "_gnd"},  {31'd0, p7_w[w]},   32'd0);
  endtask

  // One full run on instance w; extra start pulse after edge pulse_at (0 = none).
  task automatic run_one(input int w, input int pulse_at, input string tag);
    int exp_err;
    int exp_eg;
    int exp_ff;
    int exp_ffv;
    int settle;
    int n;
    bit got;
    bit truth;
    bit obs;
    exp_err = 0; exp_eg = 0; exp_ff = 0; exp_ffv = 0;
    for (int v = 0; v < 8; v++) begin
      for (int g = 0; g < 3; g++) begin
        truth = (v == 7);
        obs   = (fault_pin == g + 1) ? fault_val : truth;
        if (obs != truth) begin
          exp_err++;
          exp_eg = exp_eg | (1 << g);
          if (exp_ffv == 0) begin
            exp_ffv = 1;
            exp_ff  = g * 8 + v;
          end
        end
      end
    end
    settle = (w == 0) ? 2 : 4;

    @(negedge clk);
    st[w] = 1'b1;
    @(posedge clk);
    #1;
    st[w] = 1'b0;
    chk({tag, "_busy_rise"}, {31'd0, busy_w[w]}, 32'd1);
    n = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      @(posedge clk);
      n++;
      #1;
      st[w] = (pulse_at != 0 && n == pulse_at);
      if (done_w[w]) got = 1'b1;
    end
    st[w] = 1'b0;
    chk({tag, "_done_cycle"}, n, 24 * (settle + 2) + 1);
    chk({tag, "_tc"},  {24'd0, tc_w[w]},  32'd24);
    chk({tag, "_ec"},  {24'd0, ec_w[w]},  exp_err);
    chk({tag, "_eg"},  {29'd0, eg_w[w]},  exp_eg);
    chk({tag, "_ffv"}, {31'd0, ffv_w[w]}, exp_ffv);
    chk({tag, "_ff"},  {27'd0, ff_w[w]},  exp_ff);
    chk({tag, "_busy_fall"}, {31'd0, busy_w[w]}, 32'd0);
    chk({tag, "_pins_final"}, {23'd0, drv[w]}, 32'h1FF);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done_w[w]}, 32'd0);
    chk({tag, "_tc_hold"}, {24'd0, tc_w[w]}, 32'd24);
  endtask

  initial begin
    int w;
    n_vec = 0;
    n_miss = 0;
    st[0] = 1'b0;
    st[1] = 1'b0;
    fault_pin = 0;
    fault_val = 1'b0;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state(0, "rst0");
    chk_reset_state(1, "rst1");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Good device, both settle values; extra start mid-run on SETTLE=4.
    run_one(0, 0, "good_s2");
    run_one(1, 50, "good_s4_ignore");

    fault_pin = 3; fault_val = 1'b0;
    run_one(0, 0, "p8_sa0");
    fault_pin = 2; fault_val = 1'b1;
    run_one(0, 0, "p6_sa1");

    // Back-to-back: faulty then good, no carry-over.
    fault_pin = 1; fault_val = 1'b0;
    run_one(0, 0, "p12_sa0");
    fault_pin = 0;
    run_one(0, 0, "after_fault");

    // Reset mid-run.
    fault_pin = 0;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state(0, "midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(0, 0, "post_rst");

    // Randomized faults on randomly chosen instance.
    for (int i = 0; i < 8; i++) begin
      fault_pin = $urandom_range(0, 3);
      fault_val = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 1);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_one(w, 0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
